// File: rtl/core_dbg_ctrl.sv
// core_dbg_ctrl: multi-core debug controller serving halt/resume,
// register and PC access, single-step and hardware breakpoints.
module core_dbg_ctrl #(
    parameter int NCORES = 1,
    parameter int XLEN   = 32,
    parameter int NBRK   = 4
) (
    input  logic                   clk,
    input  logic                   rstn_i,
    input  logic [7:0]             dbg_cmd_i,
    input  logic [31:0]            dbg_addr_i,
    input  logic [XLEN-1:0]        dbg_data_i,
    output logic [XLEN-1:0]        dbg_data_o,
    output logic                   dbg_done_o,
    output logic                   dbg_err_o,
    output logic [NCORES-1:0]      halt_o,
    input  logic [NCORES-1:0]      halt_ack_i,
    input  logic [NCORES-1:0]      retire_i,
    input  logic [NCORES*XLEN-1:0] pc_i,
    output logic [4:0]             rs_o,
    input  logic [NCORES*XLEN-1:0] rs_di,
    output logic [4:0]             rd_o,
    output logic [XLEN-1:0]        rd_do,
    output logic [NCORES-1:0]      rd_we_o,
    output logic [NCORES-1:0]      flush_o,
    output logic [XLEN-1:0]        pc_o
);

    localparam int CW = (NCORES > 1) ? $clog2(NCORES) : 1;

    localparam logic [7:0] C_HALT = 8'h01;
    localparam logic [7:0] C_RES  = 8'h02;
    localparam logic [7:0] C_RREG = 8'h03;
    localparam logic [7:0] C_WREG = 8'h04;
    localparam logic [7:0] C_RPC  = 8'h05;
    localparam logic [7:0] C_WPC  = 8'h06;
    localparam logic [7:0] C_STEP = 8'h07;
    localparam logic [7:0] C_BSET = 8'h08;
    localparam logic [7:0] C_BCLR = 8'h09;
    localparam logic [7:0] C_STAT = 8'h0A;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ACK,
        S_STEP,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [7:0]       cmd_q, cmd_d;
    logic [4:0]       reg_q, reg_d;
    logic [CW-1:0]    core_q, core_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [NCORES-1:0] halted_q, halted_d;
    logic [NCORES-1:0] tmp_halt_q, tmp_halt_d;
    logic [NCORES-1:0] bp_hit_q, bp_hit_d;
    logic [NCORES-1:0] skip_q, skip_d;
    logic [XLEN-1:0]   skip_pc_q [NCORES];
    logic [XLEN-1:0]   skip_pc_d [NCORES];

    logic [NBRK-1:0]   bp_valid_q, bp_valid_d;
    logic [XLEN-1:0]   bp_pc_q [NBRK];
    logic [XLEN-1:0]   bp_pc_d [NBRK];
    logic [CW-1:0]     bp_core_q [NBRK];
    logic [CW-1:0]     bp_core_d [NBRK];

    logic [CW-1:0]     in_core;
    logic [XLEN-1:0]   in_pc;
    logic              in_halted;
    logic [XLEN-1:0]   cur_rs;
    logic              cur_ack;
    logic              cur_retire;
    logic              cmd_known;
    logic              core_ok;
    logic              bp_ok;
    logic              is_bp_cmd;
    logic              in_err;
    logic [XLEN-1:0]   status;
    logic [NCORES-1:0] bp_match;
    logic              act;
    logic              unused_addr;

    assign unused_addr = ^dbg_addr_i[23:5];

    assign in_core = dbg_addr_i[24 +: CW];

    always_comb begin
        in_pc      = '0;
        in_halted  = 1'b0;
        cur_rs     = '0;
        cur_ack    = 1'b0;
        cur_retire = 1'b0;
        for (int k = 0; k < NCORES; k++) begin
            if (in_core == CW'(k)) begin
                in_pc     = pc_i[k*XLEN +: XLEN];
                in_halted = halted_q[k];
            end
            if (core_q == CW'(k)) begin
                cur_rs     = rs_di[k*XLEN +: XLEN];
                cur_ack    = halt_ack_i[k];
                cur_retire = retire_i[k];
            end
        end
    end

    assign cmd_known = (dbg_cmd_i >= C_HALT) && (dbg_cmd_i <= C_STAT);
    assign core_ok   = 32'(dbg_addr_i[31:24]) < 32'(NCORES);
    assign bp_ok     = 32'(dbg_addr_i[4:0]) < 32'(NBRK);
    assign is_bp_cmd = (dbg_cmd_i == C_BSET) || (dbg_cmd_i == C_BCLR);
    assign in_err    = !cmd_known || !core_ok
                     || (is_bp_cmd && !bp_ok)
                     || ((dbg_cmd_i == C_STEP) && !in_halted);

    always_comb begin
        status = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (k < XLEN) status[k] = halted_q[k];
            if (16 + k < XLEN) status[16+k] = bp_hit_q[k];
        end
    end

    // A match is ignored while halted or while still parked on the resume PC.
    always_comb begin
        bp_match = '0;
        for (int k = 0; k < NCORES; k++) begin
            for (int b = 0; b < NBRK; b++) begin
                if (bp_valid_q[b] && bp_core_q[b] == CW'(k)
                    && pc_i[k*XLEN +: XLEN] == bp_pc_q[b])
                    bp_match[k] = 1'b1;
            end
            if (halted_q[k]) bp_match[k] = 1'b0;
            if (skip_q[k] && pc_i[k*XLEN +: XLEN] == skip_pc_q[k])
                bp_match[k] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (dbg_cmd_i != 8'h00) begin
                    if (in_err) begin
                        state_d = S_DONE;
                    end else begin
                        unique case (dbg_cmd_i)
                            C_HALT, C_RREG,
                            C_WREG, C_WPC: state_d = S_WAIT_ACK;
                            C_STEP:        state_d = S_STEP;
                            default:       state_d = S_DONE;
                        endcase
                    end
                end
            end
            S_WAIT_ACK: if (cur_ack) state_d = S_DONE;
            S_STEP:     if (cur_retire) state_d = S_DONE;
            S_DONE:     if (dbg_cmd_i == 8'h00) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        act     = (state_q == S_WAIT_ACK) && cur_ack;
        rs_o    = (state_q == S_WAIT_ACK) ? reg_q : 5'd0;
        rd_o    = '0;
        rd_do   = '0;
        pc_o    = '0;
        rd_we_o = '0;
        flush_o = '0;
        if (act && cmd_q == C_WREG) begin
            rd_o  = reg_q;
            rd_do = wdata_q;
        end
        if (act && cmd_q == C_WPC) pc_o = wdata_q;
        for (int k = 0; k < NCORES; k++) begin
            rd_we_o[k] = act && cmd_q == C_WREG && core_q == CW'(k);
            flush_o[k] = act && cmd_q == C_WPC && core_q == CW'(k);
        end
    end

    always_comb begin
        cmd_d      = cmd_q;
        reg_d      = reg_q;
        core_d     = core_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        halted_d   = halted_q;
        tmp_halt_d = tmp_halt_q;
        bp_hit_d   = bp_hit_q;
        skip_d     = skip_q;
        skip_pc_d  = skip_pc_q;
        bp_valid_d = bp_valid_q;
        bp_pc_d    = bp_pc_q;
        bp_core_d  = bp_core_q;
        done_d     = (state_d == S_DONE) && (state_q != S_DONE);
        err_d      = (state_q == S_IDLE) && (dbg_cmd_i != 8'h00) && in_err;

        for (int k = 0; k < NCORES; k++) begin
            if (skip_q[k] && pc_i[k*XLEN +: XLEN] != skip_pc_q[k])
                skip_d[k] = 1'b0;
            if (bp_match[k]) begin
                halted_d[k] = 1'b1;
                bp_hit_d[k] = 1'b1;
            end
        end

        // Command effects come last so a resume overrides a same-cycle hit.
        unique case (state_q)
            S_IDLE: begin
                if (dbg_cmd_i != 8'h00 && !in_err) begin
                    cmd_d   = dbg_cmd_i;
                    reg_d   = dbg_addr_i[4:0];
                    core_d  = in_core;
                    wdata_d = dbg_data_i;
                    if (dbg_cmd_i == C_RPC)  data_d = in_pc;
                    if (dbg_cmd_i == C_STAT) data_d = status;
                    for (int k = 0; k < NCORES; k++) begin
                        if (in_core == CW'(k)) begin
                            unique case (dbg_cmd_i)
                                C_HALT: halted_d[k] = 1'b1;
                                C_RREG, C_WREG,
                                C_WPC:  tmp_halt_d[k] = 1'b1;
                                C_RES, C_STEP: begin
                                    halted_d[k]  = 1'b0;
                                    bp_hit_d[k]  = 1'b0;
                                    skip_d[k]    = 1'b1;
                                    skip_pc_d[k] = in_pc;
                                end
                                default: ;
                            endcase
                        end
                    end
                    for (int b = 0; b < NBRK; b++) begin
                        if (dbg_addr_i[4:0] == 5'(b)) begin
                            if (dbg_cmd_i == C_BSET) begin
                                bp_valid_d[b] = 1'b1;
                                bp_pc_d[b]    = dbg_data_i;
                                bp_core_d[b]  = in_core;
                            end
                            if (dbg_cmd_i == C_BCLR)
                                bp_valid_d[b] = 1'b0;
                        end
                    end
                end
            end
            S_WAIT_ACK: begin
                if (cur_ack) begin
                    if (cmd_q == C_RREG) data_d = cur_rs;
                    for (int k = 0; k < NCORES; k++)
                        if (core_q == CW'(k)) tmp_halt_d[k] = 1'b0;
                end
            end
            S_STEP: begin
                if (cur_retire) begin
                    for (int k = 0; k < NCORES; k++)
                        if (core_q == CW'(k)) halted_d[k] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            cmd_q      <= '0;
            reg_q      <= '0;
            core_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            halted_q   <= '0;
            tmp_halt_q <= '0;
            bp_hit_q   <= '0;
            skip_q     <= '0;
            skip_pc_q  <= '{default: '0};
            bp_valid_q <= '0;
            bp_pc_q    <= '{default: '0};
            bp_core_q  <= '{default: '0};
        end else begin
            cmd_q      <= cmd_d;
            reg_q      <= reg_d;
            core_q     <= core_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            halted_q   <= halted_d;
            tmp_halt_q <= tmp_halt_d;
            bp_hit_q   <= bp_hit_d;
            skip_q     <= skip_d;
            skip_pc_q  <= skip_pc_d;
            bp_valid_q <= bp_valid_d;
            bp_pc_q    <= bp_pc_d;
            bp_core_q  <= bp_core_d;
        end
    end

    assign halt_o     = halted_q | tmp_halt_q;
    assign dbg_data_o = data_q;
    assign dbg_done_o = done_q;
    assign dbg_err_o  = err_q;

endmodule

// File: tb/tb_core_dbg_ctrl.sv
// Directed bench for core_dbg_ctrl with two cores.
// Core 1 acks from its own halt_o; core 0 ack is driven by hand.
module tb_core_dbg_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data_o;
    logic        done;
    logic        err;
    logic [1:0]  halt_o;
    logic [1:0]  ack;
    logic        ack0;
    logic [1:0]  retire;
    logic [31:0] pc0, pc1, rs0, rs1;
    logic [4:0]  rs_o;
    logic [4:0]  rd_o;
    logic [31:0] rd_do;
    logic [1:0]  rd_we;
    logic [1:0]  flush;
    logic [31:0] pc_o;
    int          errors = 0;
    int          checks = 0;
    int          dones;

    assign ack = {halt_o[1], ack0};

    always #5 clk = ~clk;

    core_dbg_ctrl #(.NCORES(2), .XLEN(32), .NBRK(4)) dut (
        .clk        (clk),
        .rstn_i     (rstn),
        .dbg_cmd_i  (cmd),
        .dbg_addr_i (addr),
        .dbg_data_i (wdata),
        .dbg_data_o (data_o),
        .dbg_done_o (done),
        .dbg_err_o  (err),
        .halt_o     (halt_o),
        .halt_ack_i (ack),
        .retire_i   (retire),
        .pc_i       ({pc1, pc0}),
        .rs_o       (rs_o),
        .rs_di      ({rs1, rs0}),
        .rd_o       (rd_o),
        .rd_do      (rd_do),
        .rd_we_o    (rd_we),
        .flush_o    (flush),
        .pc_o       (pc_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [31:0] a,
                        input logic [31:0] d);
        cmd   = c;
        addr  = a;
        wdata = d;
        tick();
    endtask

    task automatic release_cmd();
        cmd = 8'h00;
        tick();
    endtask

    initial begin
        cmd = 0; addr = 0; wdata = 0; ack0 = 0; retire = 0;
        pc0 = 32'h1000; pc1 = 32'h7C;
        rs0 = 32'h1111_1111; rs1 = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("rst_halt", 32'(halt_o), 0);
        chk("rst_done_err", {30'd0, done, err}, 0);
        chk("rst_data", data_o, 0);
        chk("rst_rs", 32'(rs_o), 0);
        chk("rst_we_flush", {28'd0, rd_we, flush}, 0);
        chk("rst_pc_o", pc_o, 0);
        rstn = 1'b1;
        tick();

        send(8'h03, 32'h0100_0005, 0);
        chk("rreg_halt_c1", 32'(halt_o), 2);
        chk("rreg_rs_c1", 32'(rs_o), 5);
        chk("rreg_done_c1", 32'(done), 0);
        tick();
        chk("rreg_done_c2", 32'(done), 1);
        chk("rreg_data", data_o, 32'hDEAD_BEEF);
        chk("rreg_halt_c2", 32'(halt_o), 0);
        release_cmd();
        chk("rreg_done_once", 32'(done), 0);

        send(8'h04, 32'h0000_0007, 32'h1234);
        chk("wreg_halt_c1", 32'(halt_o), 1);
        chk("wreg_we_c1", 32'(rd_we), 0);
        tick();
        chk("wreg_we_c2", 32'(rd_we), 0);
        tick();
        chk("wreg_done_c3", 32'(done), 0);
        tick();
        ack0 = 1'b1;
        #1;
        chk("wreg_we_c4", 32'(rd_we), 1);
        chk("wreg_rd_c4", 32'(rd_o), 7);
        chk("wreg_rdd_c4", rd_do, 32'h1234);
        tick();
        chk("wreg_done_c5", 32'(done), 1);
        chk("wreg_we_c5", 32'(rd_we), 0);
        chk("wreg_halt_c5", 32'(halt_o), 0);
        ack0 = 1'b0;
        release_cmd();

        send(8'h01, 32'h0, 0);
        chk("halt_c1", 32'(halt_o), 1);
        ack0 = 1'b1;
        tick();
        chk("halt_done", 32'(done), 1);
        release_cmd();

        send(8'h05, 32'h0, 0);
        chk("rpc_done", 32'(done), 1);
        chk("rpc_data", data_o, 32'h1000);
        release_cmd();

        send(8'h07, 32'h0, 0);
        chk("step_drop", 32'(halt_o), 0);
        chk("step_done_c1", 32'(done), 0);
        ack0 = 1'b0;
        tick();
        chk("step_wait", 32'(halt_o), 0);
        retire = 2'b01;
        tick();
        retire = 2'b00;
        chk("step_rehalt", 32'(halt_o), 1);
        chk("step_done", {30'd0, done, err}, 2);
        ack0 = 1'b1;
        release_cmd();

        send(8'h0A, 32'h0, 0);
        chk("stat_halt0", data_o, 32'h1);
        release_cmd();

        send(8'h07, 32'h0100_0000, 0);
        chk("step_run_err", {30'd0, done, err}, 3);
        chk("step_run_halt", 32'(halt_o), 1);
        release_cmd();

        send(8'h02, 32'h0, 0);
        chk("res_done", {30'd0, done, err}, 2);
        chk("res_halt", 32'(halt_o), 0);
        ack0 = 1'b0;
        release_cmd();

        send(8'h08, 32'h0100_0000, 32'h80);
        chk("bset_done", {30'd0, done, err}, 2);
        release_cmd();
        pc1 = 32'h80;
        #1;
        chk("bp_not_yet", 32'(halt_o), 0);
        tick();
        chk("bp_hit_halt", 32'(halt_o), 2);
        send(8'h0A, 32'h0100_0000, 0);
        chk("bp_status", data_o, 32'h0002_0002);
        release_cmd();

        send(8'h02, 32'h0100_0000, 0);
        chk("bp_res_halt", 32'(halt_o), 0);
        release_cmd();
        tick();
        tick();
        tick();
        chk("bp_skip", 32'(halt_o), 0);
        send(8'h0A, 32'h0, 0);
        chk("bp_status_clr", data_o, 32'h0);
        release_cmd();
        pc1 = 32'h84;
        tick();
        pc1 = 32'h80;
        tick();
        chk("bp_rehit", 32'(halt_o), 2);

        send(8'h02, 32'h0100_0000, 0);
        release_cmd();
        send(8'h09, 32'h0100_0000, 0);
        chk("bclr_done", {30'd0, done, err}, 2);
        release_cmd();
        pc1 = 32'h84;
        tick();
        pc1 = 32'h80;
        tick();
        chk("bclr_nohit", 32'(halt_o), 0);

        send(8'h06, 32'h0100_0000, 32'h200);
        chk("wpc_flush", 32'(flush), 2);
        chk("wpc_pc", pc_o, 32'h200);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) begin
                chk("wpc_done", 32'(done), 1);
                chk("wpc_flush_off", 32'(flush), 0);
                chk("wpc_halt_off", 32'(halt_o), 0);
            end
            dones += int'(done);
        end
        chk("hold_one_done", 32'(dones), 1);
        release_cmd();

        send(8'h03, 32'h0500_0003, 0);
        chk("bad_core_err", {30'd0, done, err}, 3);
        chk("bad_core_out", {25'd0, halt_o, rs_o}, 0);
        chk("bad_core_we", {28'd0, rd_we, flush}, 0);
        release_cmd();
        send(8'h0B, 32'h0, 0);
        chk("bad_cmd_err", {30'd0, done, err}, 3);
        release_cmd();
        send(8'h08, 32'h0000_0004, 32'h40);
        chk("bad_bp_err", {30'd0, done, err}, 3);
        release_cmd();

        send(8'h03, 32'h0000_0003, 0);
        chk("rst_mid_halt", 32'(halt_o), 1);
        chk("rst_mid_rs", 32'(rs_o), 3);
        rstn = 1'b0;
        #1;
        chk("rst_mid_out", {25'd0, halt_o, rs_o}, 0);
        chk("rst_mid_done", {30'd0, done, err}, 0);
        cmd = 8'h00;
        tick();
        rstn = 1'b1;
        tick();
        chk("rst_after", {28'd0, halt_o, done, err}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
